// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: substitutes LANES bytes of a 128-bit state per clock,
// forward or inverse S-box, with valid/ready handshakes on both sides.

module sub_bytes_lane #(
    parameter bit INV_SUPPORT = 1'b1
) (
    input  logic [7:0] din,
    input  logic       inverse,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    generate
        if (INV_SUPPORT) begin : g_inv
            assign dout = inverse ? INV[din] : FWD[din];
        end else begin : g_fwd
            logic unused_inverse;
            assign unused_inverse = inverse;
            assign dout = FWD[din];
        end
    endgenerate
endmodule

module sub_bytes_seq #(
    parameter int LANES       = 4,
    parameter bit INV_SUPPORT = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_state,
    input  logic         i_inverse,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state,
    output logic         o_busy
);
    localparam int         STEPS = 16 / LANES;
    localparam logic [3:0] LAST  = 4'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt;
    logic                   mode;
    logic [127:0]           work;
    logic [6:0]             base;
    logic [LANES-1:0][7:0]  lane_in, lane_out;
    logic                   accept;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Byte 0 sits at the MSB, so the window for step cnt starts at bit 127 - 8*LANES*cnt.
    always_comb base = 7'(127 - 8 * LANES * int'(cnt));
    assign lane_in = work[base -: 8*LANES];

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            sub_bytes_lane #(.INV_SUPPORT(INV_SUPPORT)) u_lane (
                .din     (lane_in[l]),
                .inverse (mode),
                .dout    (lane_out[l])
            );
        end
    endgenerate

    assign accept = i_valid && o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // o_ready is gated by i_rst so nothing can be accepted while reset is held.
    always_comb begin
        o_ready = (state == IDLE) && !i_rst;
        o_valid = (state == DONE);
        o_busy  = (state != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            work <= '0;
            cnt  <= '0;
            mode <= 1'b0;
        end else if (state == IDLE && accept) begin
            work <= i_state;
            cnt  <= '0;
            mode <= INV_SUPPORT && i_inverse;
        end else if (state == RUN) begin
            work[base -: 8*LANES] <= lane_out;
            cnt                   <= cnt + 4'd1;
        end
    end

    assign o_state = work;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: vector table on a LANES=4 instance, hand
// sequences for backpressure, back-to-back and reset abort, plus a parameter sweep.

module tb_sub_bytes_seq;
    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid, i_inverse, i_ready;
    logic [127:0] i_state;
    logic         o_ready, o_valid, o_busy;
    logic [127:0] o_state;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    sub_bytes_seq #(.LANES(4), .INV_SUPPORT(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_state(i_state), .i_inverse(i_inverse), .o_valid(o_valid),
        .i_ready(i_ready), .o_state(o_state), .o_busy(o_busy)
    );

    // sweep instances: LANES 1, 2, 8, 16 with inverse support, then LANES 4 forward-only
    logic         sv_valid, sv_ready;
    logic [127:0] sv_state;
    logic [4:0]   sv_inv, sv_ordy, sv_ovld, sv_busy;
    logic [127:0] sv_ost [5];

    generate
        for (genvar g = 0; g < 5; g++) begin : g_sw
            sub_bytes_seq #(
                .LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : (g == 3) ? 16 : 4),
                .INV_SUPPORT((g == 4) ? 1'b0 : 1'b1)
            ) u_sw (
                .i_clk(i_clk), .i_rst(i_rst), .i_valid(sv_valid), .o_ready(sv_ordy[g]),
                .i_state(sv_state), .i_inverse(sv_inv[g]), .o_valid(sv_ovld[g]),
                .i_ready(sv_ready), .o_state(sv_ost[g]), .o_busy(sv_busy[g])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_one(input logic [127:0] din, input logic inv, input logic [127:0] exp, input int hold);
        int c;
        chk("ready_before_accept", 128'(o_ready), 128'd1);
        i_valid = 1'b1; i_state = din; i_inverse = inv; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_state = ~din;
        chk("busy_in_run", 128'(o_busy), 128'd1);
        c = 0;
        while (!o_valid && c < 40) begin
            i_inverse = ~i_inverse;
            @(posedge i_clk); #1;
            c++;
        end
        chk("latency", 128'(c), 128'd4);
        chk("result", o_state, exp);
        chk("ready_in_done", 128'(o_ready), 128'd0);
        i_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk); #1;
            chk("hold_valid", 128'(o_valid), 128'd1);
            chk("hold_state", o_state, exp);
            chk("hold_ready", 128'(o_ready), 128'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("valid_after_deliver", 128'(o_valid), 128'd0);
        chk("ready_after_deliver", 128'(o_ready), 128'd1);
        chk("busy_after_deliver", 128'(o_busy), 128'd0);
        chk("state_kept", o_state, exp);
        i_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] b2b_in [2];
        logic [127:0] b2b_exp [2];
        int acc [2];
        int k, d, lat [5];
        logic [127:0] sw_out [5];
        int sw_lat_exp [5];
        bit seen_valid;

        vecs[0] = '{din: 128'h00102030405060708090a0b0c0d0e0f0, inv: 1'b0, exp: 128'h63cab7040953d051cd60e0e7ba70e18c, hold: 0};
        vecs[1] = '{din: 128'h63cab7040953d051cd60e0e7ba70e18c, inv: 1'b1, exp: 128'h00102030405060708090a0b0c0d0e0f0, hold: 0};
        vecs[2] = '{din: 128'ha761ca9b97be8b45d8ad1a611fc97369, inv: 1'b1, exp: 128'h89d810e8855ace682d1843d8cb128fe4, hold: 0};
        vecs[3] = '{din: 128'hc81677bc9b7ac93b25027992b0261996, inv: 1'b0, exp: 128'he847f56514dadde23f77b64fe7f7d490, hold: 5};
        vecs[4] = '{din: 128'h4915598f55e5d7a0daca94fa1f0a63f7, inv: 1'b0, exp: 128'h3b59cb73fcd90ee05774222dc067fb68, hold: 1};
        vecs[5] = '{din: 128'h3b59cb73fcd90ee05774222dc067fb68, inv: 1'b1, exp: 128'h4915598f55e5d7a0daca94fa1f0a63f7, hold: 0};

        i_rst = 1'b1; i_valid = 1'b0; i_inverse = 1'b0; i_ready = 1'b0; i_state = '0;
        sv_valid = 1'b0; sv_ready = 1'b0; sv_state = '0; sv_inv = '0;
        #2;
        chk("rst_ready", 128'(o_ready), 128'd0);
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_state", o_state, 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        chk("ready_after_release", 128'(o_ready), 128'd1);
        @(posedge i_clk); #1;

        for (int i = 0; i < 6; i++)
            run_one(vecs[i].din, vecs[i].inv, vecs[i].exp, vecs[i].hold);

        // back-to-back with i_valid and i_ready held high
        b2b_in[0]  = 128'h4915598f55e5d7a0daca94fa1f0a63f7;
        b2b_in[1]  = 128'hfa636a2825b339c940668a3157244d17;
        b2b_exp[0] = 128'h3b59cb73fcd90ee05774222dc067fb68;
        b2b_exp[1] = 128'h2dfb02343f6d12dd09337ec75b36e3f0;
        k = 0; d = 0; acc[0] = 0; acc[1] = 0;
        i_valid = 1'b1; i_ready = 1'b1; i_inverse = 1'b0; i_state = b2b_in[0];
        for (int cyc = 0; cyc < 60 && d < 2; cyc++) begin
            if (o_valid) begin
                chk("b2b_result", o_state, b2b_exp[d]);
                d++;
            end
            if (o_ready && i_valid && k < 2) begin
                acc[k] = cyc;
                k++;
            end
            @(posedge i_clk); #1;
            if (k == 1) i_state = b2b_in[1];
            else if (k == 2) i_valid = 1'b0;
        end
        chk("b2b_deliveries", 128'(d), 128'd2);
        chk("b2b_accept_spacing", 128'(acc[1] - acc[0]), 128'd6);
        i_valid = 1'b0; i_ready = 1'b0;
        @(posedge i_clk); #1;

        // reset two cycles into RUN
        i_valid = 1'b1; i_inverse = 1'b0; i_state = 128'h247240236966b3fa6ed2753288425b6c;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("busy_before_abort", 128'(o_busy), 128'd1);
        i_rst = 1'b1;
        #1;
        chk("abort_valid", 128'(o_valid), 128'd0);
        chk("abort_state", o_state, 128'd0);
        chk("abort_busy", 128'(o_busy), 128'd0);
        chk("abort_ready", 128'(o_ready), 128'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        chk("abort_ready_release", 128'(o_ready), 128'd1);
        seen_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen_valid = 1'b1;
        end
        i_ready = 1'b0;
        chk("abort_no_result", 128'(seen_valid), 128'd0);
        run_one(128'h247240236966b3fa6ed2753288425b6c, 1'b0, 128'h36400926f9336d2d9fb59d23c42c3950, 0);

        // parameter sweep: same forward vector, forward-only instance gets i_inverse = 1
        sw_lat_exp[0] = 16; sw_lat_exp[1] = 8; sw_lat_exp[2] = 2; sw_lat_exp[3] = 1; sw_lat_exp[4] = 4;
        for (int g = 0; g < 5; g++) begin
            lat[g] = -1;
            sw_out[g] = '0;
        end
        chk("sweep_ready", 128'(sv_ordy), 128'h1f);
        sv_valid = 1'b1; sv_ready = 1'b1; sv_inv = 5'b10000;
        sv_state = 128'h00102030405060708090a0b0c0d0e0f0;
        @(posedge i_clk); #1;
        sv_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            for (int g = 0; g < 5; g++)
                if (sv_ovld[g] && lat[g] < 0) begin
                    lat[g] = c;
                    sw_out[g] = sv_ost[g];
                end
            @(posedge i_clk); #1;
        end
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("sweep_latency_%0d", g), 128'(lat[g]), 128'(sw_lat_exp[g]));
            chk($sformatf("sweep_result_%0d", g), sw_out[g], 128'h63cab7040953d051cd60e0e7ba70e18c);
        end
        chk("sweep_idle", 128'(sv_busy), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Parametrised, sequential successor to the combinational SubBytes stage. It accepts a 128-bit AES state over a valid/ready handshake and applies either the forward or the inverse S-box, LANES bytes per clock. The result is presented over a valid/ready handshake. Encryption and decryption round controllers share it, trading S-box area against latency.

Parameters:
- LANES, 4: S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- INV_SUPPORT, 1: 1 instantiates inverse S-boxes and honours i_inverse. 0 omits them; i_inverse is ignored and the block is forward-only.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  upstream presents a state.
- o_ready  output  1  block can accept a state.
- i_state  input  128  input state; byte 0 = bits [127:120].
- i_inverse  input  1  0 = forward S-box, 1 = inverse S-box; sampled on acceptance.
- o_valid  output  1  o_state holds a completed result.
- i_ready  input  1  downstream accepts the result.
- o_state  output  128  substituted state, same byte order as i_state.
- o_busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; o_valid = 0; o_state = 0; o_busy = 0; byte counter = 0; latched mode = 0.
  - o_ready = 0 while i_rst is high; o_ready = 1 in the first cycle after release.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_ready = 1.
  - On a rising edge with i_valid && o_ready: latch i_state into the working register, latch i_inverse (forced to 0 when INV_SUPPORT = 0), clear the counter, go to RUN.
  - While i_valid is low, nothing changes.
- RUN:
  - o_ready = 0.
  - Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register are replaced by S(byte) or S^-1(byte), starting from byte 0 (MSB).
  - cnt increments each cycle. After the cycle that processes cnt = 16/LANES - 1, go to DONE.
- DONE:
  - o_valid = 1; o_state = working register, held stable while i_ready is low.
  - On o_valid && i_ready: o_valid drops, go to IDLE.
  - o_ready stays 0 in DONE, so accept and deliver never overlap. The earliest next accept is one cycle after delivery.
- Latency: accept edge at T; o_valid is high in the cycle after edge T + 16/LANES.
  - LANES = 16: o_valid is high the cycle after accept.
  - LANES = 1: 16 RUN cycles.
- Throughput: one state per 16/LANES + 2 cycles with i_ready held high.
- o_state: don't-care outside DONE (it shows partial substitution during RUN). After delivery it keeps its value until the next accept.
- i_state and i_inverse changes after the accept edge have no effect on the operation in flight.
- i_ready while o_valid = 0 is ignored.
- Reset mid-RUN or mid-DONE: immediate abort, all outputs at their reset values, and no result is delivered.
- S-box: full 256-entry forward table and, when INV_SUPPORT = 1, the 256-entry inverse table, both combinational per lane.
- Bytes processed in different cycles must equal a single combinational SubBytes of the whole state.

Test Plan:
- Forward, LANES = 4:
  - i_state = 00102030405060708090a0b0c0d0e0f0, i_inverse = 0.
  - o_state = 63cab7040953d051cd60e0e7ba70e18c, with o_valid first high exactly 4 edges after accept.
- Inverse round trip:
  - i_state = 63cab7040953d051cd60e0e7ba70e18c, i_inverse = 1 → o_state = 00102030405060708090a0b0c0d0e0f0.
  - i_state = a761ca9b97be8b45d8ad1a611fc97369, i_inverse = 1 → 89d810e8855ace682d1843d8cb128fe4.
- Backpressure and mode latch:
  - i_state = c81677bc9b7ac93b25027992b0261996, forward; hold i_ready = 0 for 5 cycles after o_valid.
  - o_state stays e847f56514dadde23f77b64fe7f7d490 and o_ready stays 0.
  - Toggling i_inverse during RUN has no effect.
- Back-to-back, i_valid and i_ready held high:
  - 4915598f55e5d7a0daca94fa1f0a63f7 → 3b59cb73fcd90ee05774222dc067fb68.
  - fa636a2825b339c940668a3157244d17 → 2dfb02343f6d12dd09337ec75b36e3f0.
  - Accepts are exactly 16/LANES + 2 cycles apart.
- Reset mid-RUN:
  - Assert i_rst 2 cycles after accepting 247240236966b3fa6ed2753288425b6c.
  - o_valid = 0, o_state = 0, o_busy = 0 immediately; o_ready = 1 the first cycle after release.
  - Re-submit → 36400926f9336d2d9fb59d23c42c3950.
- Parameter sweep:
  - Repeat the first scenario for LANES = 1, 2, 8 and 16; latencies are 16, 8, 2 and 1 cycles, with identical results.
  - With INV_SUPPORT = 0 and i_inverse = 1, the output is the forward result 63cab704….
